e203_tcm_mport_ctrl: RTL and testbench
======================================

Name: e203_tcm_mport_ctrl

Overview:
- Parametrised multi-port TCM controller: arbitrates NUM_PORTS 32-bit ICB requestors (IFU, LSU, EXT, optional extra master) onto one single-port SRAM of width RAM_DW.
- Successor of the fixed three-port ITCM controller: generalised port count and RAM width, selectable arbitration, explicit response back-pressure buffering.
- Sits between core/bus ICB masters and the TCM RAM macro.

Parameters:
- NUM_PORTS, 3, number of ICB requestor ports (2..4); port 0 is highest priority in fixed mode.
- AW, 16, ICB byte-address width.
- RAM_DW, 64, RAM data width; 32 or 64 only.
- RAM_AW, AW-$clog2(RAM_DW/8), RAM word-address width (derived, not overridden).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- icb_cmd_valid  in  NUM_PORTS  per-port command valid.
- icb_cmd_ready  out  NUM_PORTS  per-port command ready.
- icb_cmd_addr  in  NUM_PORTS*AW  byte addresses; port i at [i*AW +: AW].
- icb_cmd_read  in  NUM_PORTS  1 = read, 0 = write.
- icb_cmd_wdata  in  NUM_PORTS*32  write data.
- icb_cmd_wmask  in  NUM_PORTS*4  byte write mask.
- icb_rsp_valid  out  NUM_PORTS  per-port response valid.
- icb_rsp_ready  in  NUM_PORTS  per-port response ready.
- icb_rsp_rdata  out  NUM_PORTS*32  read data; 0 for writes.
- ram_cs  out  1  RAM chip select.
- ram_we  out  1  RAM write enable.
- ram_addr  out  RAM_AW  RAM word address.
- ram_wem  out  RAM_DW/8  RAM byte write enables.
- ram_din  out  RAM_DW  RAM write data.
- ram_dout  in  RAM_DW  RAM read data, valid one cycle after ram_cs.
- tcm_active  out  1  high while any command is pending or any response is outstanding.

Behaviour:
Reset:
- rst_n=0 asynchronously clears rsp_pending, rsp_port, lane register, hold register, hold-valid flag and arbitration pointer (last=NUM_PORTS-1).
- All outputs are 0 during reset.
- Reset mid-transaction drops the outstanding response; no replay after reset.

Arbitration:
- One grant per cycle among valid ports.
- icb_cmd_ready[i] = grant[i] & slot_free, where slot_free = !rsp_pending | rsp_fire.
- A command fires when valid & ready. It drives ram_cs=1 combinationally in the same cycle, with ram_we = !read.

Lane mapping:
- RAM_DW=64: ram_addr = addr[AW-1:3]; addr[2] selects the lane; ram_din = {wdata,wdata}; ram_wem = wmask placed in the selected lane, other lane 0.
- RAM_DW=32: ram_addr = addr[AW-1:2]; ram_wem = wmask.
- addr[1:0] is ignored.

Response stage:
- Latency is exactly 1 cycle. On the cycle after a fire: rsp_pending=1, icb_rsp_valid[rsp_port]=1, and rdata is the registered lane of ram_dout (reads) or 0 (writes).
- If icb_rsp_ready is low on the first response cycle, ram_dout is captured into the hold register. The response is then served from that register until the handshake completes; ram_cs stays 0 meanwhile.
- Back-to-back: a response firing in cycle N allows a new command fire in cycle N, giving full throughput with 1 transfer per cycle.
- Only one command may be outstanding at a time; while the slot is busy, all icb_cmd_ready are 0.
- tcm_active = |icb_cmd_valid | rsp_pending.

Optional Feature:
- E203_TCM_RR_ARB_EN defined: round-robin arbitration. The grant goes to the first valid port after the pointer `last`, cyclically; `last` updates only on a command fire.
- Undefined: fixed priority, lowest index wins; the pointer logic is absent.

Test Plan:
- Reset, then port1 writes addr 0x0104, wdata 0xDEADBEEF, wmask 0xF -> ram_addr=0x020, ram_wem=0xF0, ram_din=0xDEADBEEF_DEADBEEF; rsp_valid[1] 1 cycle later with rdata=0.
- Port0 reads addr 0x0104 with ram_dout=0xDEADBEEF_12345678 -> rsp_rdata[0]=0xDEADBEEF; addr 0x0100 -> 0x12345678.
- Ports 0,1,2 valid continuously with rsp_ready=1 -> fixed mode grants 0,0,0,...; RR mode grants 0,1,2,0,1,2 on consecutive cycles.
- Port2 read with rsp_ready=0 for 3 cycles while ram_dout changes -> rsp_rdata stays at the first-cycle value, icb_cmd_ready=0 for all ports, ram_cs=0; data is delivered when ready rises.
- Assert rst_n=0 while rsp_valid[0]=1 -> rsp_valid drops in the same cycle without a clock edge; after release, port 0 is granted first.
- RAM_DW=32 build: write addr 0x0008, wmask 0x3 -> ram_addr=0x0002, ram_wem=0x3.

Source files
------------

// File: rtl/e203_tcm_mport_ctrl.sv
// ---------------------------------------------------------------------------
// e203_tcm_mport_ctrl
//   Multi-port TCM controller. Arbitrates NUM_PORTS 32-bit ICB requestors onto
//   one single-port SRAM of width RAM_DW (32 or 64). Only one command is in
//   flight at a time and its response comes back exactly one cycle after the
//   command fires. If the requestor stalls the response, the read data is
//   parked in a hold register because the RAM output is not stable once the
//   RAM is deselected.
//
//   Optional feature macro: E203_TCM_RR_ARB_EN
//     defined   -> round-robin arbitration (pointer `last`, moves on fire)
//     undefined -> fixed priority, lowest port index wins
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   icb_cmd_*         per-port ICB command channel (valid/ready/addr/read/
//                     wdata/wmask), port i at slice i
//   icb_rsp_*         per-port ICB response channel (valid/ready/rdata)
//   ram_cs/we/addr/wem/din  SRAM request, ram_dout = SRAM read data (1 cycle)
//   tcm_active        any command pending or a response outstanding
// ---------------------------------------------------------------------------
module e203_tcm_mport_ctrl #(
  parameter  int NUM_PORTS = 3,
  parameter  int AW        = 16,
  parameter  int RAM_DW    = 64,
  localparam int RAM_AW    = AW - $clog2(RAM_DW / 8)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_PORTS-1:0]    icb_cmd_valid,
  output logic [NUM_PORTS-1:0]    icb_cmd_ready,
  input  logic [NUM_PORTS*AW-1:0] icb_cmd_addr,
  input  logic [NUM_PORTS-1:0]    icb_cmd_read,
  input  logic [NUM_PORTS*32-1:0] icb_cmd_wdata,
  input  logic [NUM_PORTS*4-1:0]  icb_cmd_wmask,
  output logic [NUM_PORTS-1:0]    icb_rsp_valid,
  input  logic [NUM_PORTS-1:0]    icb_rsp_ready,
  output logic [NUM_PORTS*32-1:0] icb_rsp_rdata,
  output logic                    ram_cs,
  output logic                    ram_we,
  output logic [RAM_AW-1:0]       ram_addr,
  output logic [RAM_DW/8-1:0]     ram_wem,
  output logic [RAM_DW-1:0]       ram_din,
  input  logic [RAM_DW-1:0]       ram_dout,
  output logic                    tcm_active
);

  localparam int LANES = RAM_DW / 32;
  localparam int LSB   = $clog2(RAM_DW / 8);
  localparam int PW    = $clog2(NUM_PORTS);
  localparam int WEM_W = RAM_DW / 8;

  // Pick the 32-bit lane of a RAM word (lane is always 0 for a 32-bit RAM).
  function automatic logic [31:0] lane_rd(input logic [RAM_DW-1:0] word, input logic lane);
    logic [31:0] r;
    r = word[31:0];
    if ((LANES == 2) && lane) begin
      r = word[RAM_DW-1 -: 32];
    end else begin
      r = word[31:0];
    end
    return r;
  endfunction

  // Place a 4-bit byte mask into the selected lane of the RAM write mask.
  function automatic logic [WEM_W-1:0] lane_wem(input logic [3:0] mask, input logic lane);
    logic [WEM_W-1:0] m;
    m = WEM_W'(mask);
    if ((LANES == 2) && lane) begin
      m = WEM_W'({mask, 4'b0000});
    end else begin
      m = WEM_W'(mask);
    end
    return m;
  endfunction

  logic          gnt_vld_s;
  logic [PW-1:0] gnt_idx_s;
  logic          slot_free_s;
  logic          rsp_fire_s;
  logic          cmd_fire_s;
  logic [AW-1:0] sel_addr_s;
  logic          sel_read_s;
  logic [31:0]   sel_wdata_s;
  logic [3:0]    sel_wmask_s;
  logic          lane_s;
  logic [31:0]   rsp_data_s;
  logic          unused_s;

  logic          rsp_pending_r;
  logic [PW-1:0] rsp_port_r;
  logic          rsp_read_r;
  logic          lane_r;
  logic [31:0]   hold_r;
  logic          hold_vld_r;
`ifdef E203_TCM_RR_ARB_EN
  logic [PW-1:0] last_r;
`endif

  // Grant selection among valid ports.
  always_comb begin
    gnt_vld_s = 1'b0;
    gnt_idx_s = {PW{1'b0}};
`ifdef E203_TCM_RR_ARB_EN
    // Scan from the farthest candidate to the nearest so the first valid
    // port after `last` is the one left standing.
    for (int k = NUM_PORTS; k >= 1; k--) begin
      logic [PW-1:0] cand;
      cand = PW'((int'(last_r) + k) % NUM_PORTS);
      if (icb_cmd_valid[cand]) begin
        gnt_vld_s = 1'b1;
        gnt_idx_s = cand;
      end else begin
        gnt_idx_s = gnt_idx_s;
      end
    end
`else
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (icb_cmd_valid[i]) begin
        gnt_vld_s = 1'b1;
        gnt_idx_s = PW'(i);
      end else begin
        gnt_idx_s = gnt_idx_s;
      end
    end
`endif
  end

  // A completing response frees the slot in the same cycle (back-to-back).
  assign rsp_fire_s  = rsp_pending_r & icb_rsp_ready[rsp_port_r];
  assign slot_free_s = ~rsp_pending_r | rsp_fire_s;
  assign cmd_fire_s  = rst_n & gnt_vld_s & slot_free_s;

  // Mux the granted port's command fields.
  always_comb begin
    sel_addr_s  = {AW{1'b0}};
    sel_read_s  = 1'b0;
    sel_wdata_s = 32'h0000_0000;
    sel_wmask_s = 4'b0000;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (gnt_idx_s == PW'(i)) begin
        sel_addr_s  = icb_cmd_addr[i*AW +: AW];
        sel_read_s  = icb_cmd_read[i];
        sel_wdata_s = icb_cmd_wdata[i*32 +: 32];
        sel_wmask_s = icb_cmd_wmask[i*4 +: 4];
      end else begin
        sel_read_s = sel_read_s;
      end
    end
  end

  assign lane_s   = (LANES == 2) ? sel_addr_s[2] : 1'b0;
  assign unused_s = ^sel_addr_s[1:0];

  // RAM request, driven only in the cycle a command fires.
  always_comb begin
    ram_cs   = 1'b0;
    ram_we   = 1'b0;
    ram_addr = {RAM_AW{1'b0}};
    ram_wem  = {WEM_W{1'b0}};
    ram_din  = {RAM_DW{1'b0}};
    if (cmd_fire_s) begin
      ram_cs   = 1'b1;
      ram_we   = ~sel_read_s;
      ram_addr = sel_addr_s[AW-1:LSB];
      ram_wem  = sel_read_s ? {WEM_W{1'b0}} : lane_wem(sel_wmask_s, lane_s);
      ram_din  = {LANES{sel_wdata_s}};
    end else begin
      ram_cs = 1'b0;
    end
  end

  // Response data: parked copy if stalled, else live RAM lane; writes give 0.
  always_comb begin
    rsp_data_s = 32'h0000_0000;
    if (hold_vld_r) begin
      rsp_data_s = hold_r;
    end else if (rsp_read_r) begin
      rsp_data_s = lane_rd(ram_dout, lane_r);
    end else begin
      rsp_data_s = 32'h0000_0000;
    end
  end

  // Per-port handshake outputs.
  always_comb begin
    icb_cmd_ready = {NUM_PORTS{1'b0}};
    icb_rsp_valid = {NUM_PORTS{1'b0}};
    icb_rsp_rdata = {(NUM_PORTS*32){1'b0}};
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (cmd_fire_s && (gnt_idx_s == PW'(i))) begin
        icb_cmd_ready[i] = 1'b1;
      end else begin
        icb_cmd_ready[i] = 1'b0;
      end
      if (rsp_pending_r && (rsp_port_r == PW'(i))) begin
        icb_rsp_valid[i]          = 1'b1;
        icb_rsp_rdata[i*32 +: 32] = rsp_data_s;
      end else begin
        icb_rsp_valid[i] = 1'b0;
      end
    end
  end

  assign tcm_active = rst_n & ((|icb_cmd_valid) | rsp_pending_r);

  // Outstanding-response tracking and hold register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_pending_r <= 1'b0;
      rsp_port_r    <= {PW{1'b0}};
      rsp_read_r    <= 1'b0;
      lane_r        <= 1'b0;
      hold_r        <= 32'h0000_0000;
      hold_vld_r    <= 1'b0;
    end else if (cmd_fire_s) begin
      rsp_pending_r <= 1'b1;
      rsp_port_r    <= gnt_idx_s;
      rsp_read_r    <= sel_read_s;
      lane_r        <= lane_s;
      hold_vld_r    <= 1'b0;
    end else if (rsp_fire_s) begin
      rsp_pending_r <= 1'b0;
      hold_vld_r    <= 1'b0;
    end else if (rsp_pending_r && !hold_vld_r) begin
      // First response cycle stalled: RAM output is only valid now.
      hold_r     <= rsp_data_s;
      hold_vld_r <= 1'b1;
    end else begin
      hold_vld_r <= hold_vld_r;
    end
  end

`ifdef E203_TCM_RR_ARB_EN
  // Round-robin pointer, advances only when a command is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_r <= PW'(NUM_PORTS - 1);
    end else if (cmd_fire_s) begin
      last_r <= gnt_idx_s;
    end else begin
      last_r <= last_r;
    end
  end
`endif

endmodule

// File: tb/tb_e203_tcm_mport_ctrl.sv
module tb_e203_tcm_mport_ctrl;
  localparam int N  = 3;
  localparam int AW = 16;
  localparam int DW = 64;

  logic clk = 1'b0;
  logic rst_n;
  logic [N-1:0]    icb_cmd_valid, icb_cmd_ready, icb_cmd_read;
  logic [N*AW-1:0] icb_cmd_addr;
  logic [N*32-1:0] icb_cmd_wdata, icb_rsp_rdata;
  logic [N*4-1:0]  icb_cmd_wmask;
  logic [N-1:0]    icb_rsp_valid, icb_rsp_ready;
  logic            ram_cs, ram_we, tcm_active;
  logic [12:0]     ram_addr;
  logic [7:0]      ram_wem;
  logic [63:0]     ram_din, ram_dout;

  // 32-bit RAM build, used only for the lane-mapping check
  logic [N-1:0]    c32_valid, c32_ready, c32_read, c32_rvalid;
  logic [N*AW-1:0] c32_addr;
  logic [N*32-1:0] c32_wdata, c32_rdata;
  logic [N*4-1:0]  c32_wmask;
  logic            c32_cs, c32_we, c32_active;
  logic [13:0]     c32_raddr;
  logic [3:0]      c32_wem;
  logic [31:0]     c32_din;

  always #5 clk = ~clk;

  e203_tcm_mport_ctrl #(.NUM_PORTS(N), .AW(AW), .RAM_DW(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .icb_cmd_valid(icb_cmd_valid), .icb_cmd_ready(icb_cmd_ready),
    .icb_cmd_addr(icb_cmd_addr), .icb_cmd_read(icb_cmd_read),
    .icb_cmd_wdata(icb_cmd_wdata), .icb_cmd_wmask(icb_cmd_wmask),
    .icb_rsp_valid(icb_rsp_valid), .icb_rsp_ready(icb_rsp_ready),
    .icb_rsp_rdata(icb_rsp_rdata),
    .ram_cs(ram_cs), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wem(ram_wem),
    .ram_din(ram_din), .ram_dout(ram_dout), .tcm_active(tcm_active));

  e203_tcm_mport_ctrl #(.NUM_PORTS(N), .AW(AW), .RAM_DW(32)) dut32 (
    .clk(clk), .rst_n(rst_n),
    .icb_cmd_valid(c32_valid), .icb_cmd_ready(c32_ready),
    .icb_cmd_addr(c32_addr), .icb_cmd_read(c32_read),
    .icb_cmd_wdata(c32_wdata), .icb_cmd_wmask(c32_wmask),
    .icb_rsp_valid(c32_rvalid), .icb_rsp_ready({N{1'b1}}),
    .icb_rsp_rdata(c32_rdata),
    .ram_cs(c32_cs), .ram_we(c32_we), .ram_addr(c32_raddr), .ram_wem(c32_wem),
    .ram_din(c32_din), .ram_dout(32'h0000_0000), .tcm_active(c32_active));

  typedef struct { int port; logic [31:0] data; } exp_t;
  exp_t sb[$];
  logic [7:0]  ref_mem [0:511];
  logic [63:0] mem [0:63];
  logic        ram_clr;
  int errors, checks, m_last, arb_exp[6];
  bit chk_en;

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  function automatic int arb(input logic [N-1:0] v, input int last);
`ifdef E203_TCM_RR_ARB_EN
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (last + k) % N;
      if (v[c]) return c;
    end
`else
    for (int i = 0; i < N; i++) if (v[i]) return i;
`endif
    return -1;
  endfunction

  // SRAM model: 1-cycle read; output is garbage whenever no read was issued.
  always @(posedge clk) begin
    if (ram_clr) begin
      for (int w = 0; w < 64; w++) mem[w] <= 64'h0;
    end else if (ram_cs && ram_we) begin
      for (int b = 0; b < 8; b++)
        if (ram_wem[b]) mem[ram_addr[5:0]][b*8 +: 8] <= ram_din[b*8 +: 8];
    end
    if (ram_cs && !ram_we) ram_dout <= mem[ram_addr[5:0]];
    else ram_dout <= {$urandom, $urandom};
  end

  // Response monitor: pops the scoreboard on each response handshake.
  always @(negedge clk) begin : rsp_mon
    logic [N-1:0] ev;
    int p;
    if (chk_en) begin
      ev = '0;
      if (sb.size() != 0) ev[sb[0].port] = 1'b1;
      check("tcm_active", tcm_active, (|icb_cmd_valid) || (sb.size() != 0));
      check("rsp_valid", icb_rsp_valid, ev);
      if (sb.size() != 0) begin
        p = sb[0].port;
        if (icb_rsp_valid[p]) begin
          check("rsp_rdata", icb_rsp_rdata[p*32 +: 32], sb[0].data);
          if (icb_rsp_ready[p]) void'(sb.pop_front());
        end
      end
    end
  end

  // Command acceptance: reference arbitration, RAM mapping, scoreboard push.
  always @(negedge clk) begin : cmd_mon
    int g, a, b0;
    logic [N-1:0] er;
    logic [31:0] wd, rd;
    logic [3:0] wm;
    #1;
    if (chk_en) begin
      g  = arb(icb_cmd_valid, m_last);
      er = '0;
      if (g >= 0 && sb.size() == 0) er[g] = 1'b1;
      check("cmd_ready", icb_cmd_ready, er);
      if (er != 0) begin
        a  = int'(icb_cmd_addr[g*AW +: AW]);
        b0 = a - (a % 4);
        wd = icb_cmd_wdata[g*32 +: 32];
        wm = icb_cmd_wmask[g*4 +: 4];
        check("ram_cs", ram_cs, 1);
        check("ram_we", ram_we, !icb_cmd_read[g]);
        check("ram_addr", ram_addr, a / 8);
        check("ram_din", ram_din, {wd, wd});
        if (icb_cmd_read[g]) begin
          rd = {ref_mem[b0+3], ref_mem[b0+2], ref_mem[b0+1], ref_mem[b0]};
          sb.push_back('{g, rd});
        end else begin
          check("ram_wem", ram_wem, 64'(wm) << (4 * ((a / 4) % 2)));
          for (int b = 0; b < 4; b++) if (wm[b]) ref_mem[b0+b] = wd[b*8 +: 8];
          sb.push_back('{g, 32'h0});
        end
        m_last = g;
      end else begin
        check("ram_idle", ram_cs, 0);
      end
    end
  end

  task automatic set_cmd(input int p, input logic [15:0] a, input logic rd,
                         input logic [31:0] wd, input logic [3:0] wm);
    icb_cmd_valid[p] = 1'b1;
    icb_cmd_addr[p*AW +: AW] = a;
    icb_cmd_read[p] = rd;
    icb_cmd_wdata[p*32 +: 32] = wd;
    icb_cmd_wmask[p*4 +: 4] = wm;
  endtask

  task automatic drive_cmd(input int p, input logic [15:0] a, input logic rd,
                           input logic [31:0] wd, input logic [3:0] wm);
    @(posedge clk); #1;
    set_cmd(p, a, rd, wd, wm);
  endtask

  // Returns at negedge+2 of the cycle in which port p is accepted.
  task automatic wait_accept(input int p);
    int n;
    n = 0;
    do begin
      @(negedge clk); #2;
      n++;
    end while (!icb_cmd_ready[p] && n < 50);
    check("accept_timeout", icb_cmd_ready[p], 1);
  endtask

  task automatic clear_cmd(input int p);
    @(posedge clk); #1;
    icb_cmd_valid[p] = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [N-1:0] acc, eg;
    errors = 0; checks = 0; chk_en = 0; m_last = N - 1; ram_clr = 1'b1;
`ifdef E203_TCM_RR_ARB_EN
    arb_exp = '{0, 1, 2, 0, 1, 2};
`else
    arb_exp = '{0, 0, 0, 0, 0, 0};
`endif
    for (int i = 0; i < 512; i++) ref_mem[i] = 8'h00;
    rst_n = 1'b0;
    icb_cmd_valid = '1; icb_cmd_read = '1; icb_cmd_addr = '0;
    icb_cmd_wdata = '0; icb_cmd_wmask = '0; icb_rsp_ready = '1;
    c32_valid = '0; c32_read = '0; c32_addr = '0; c32_wdata = '0; c32_wmask = '0;
    #12;
    check("rst_cmd_ready", icb_cmd_ready, 0);
    check("rst_ram_cs", ram_cs, 0);
    check("rst_active", tcm_active, 0);
    check("rst_rsp_valid", icb_rsp_valid, 0);
    check("rst_rsp_rdata", icb_rsp_rdata, 0);
    icb_cmd_valid = '0;
    #1 rst_n = 1'b1; ram_clr = 1'b0; chk_en = 1;

    // 32-bit RAM lane mapping
    @(posedge clk); #1;
    c32_valid[0] = 1'b1; c32_addr[15:0] = 16'h0008; c32_wmask[3:0] = 4'h3;
    c32_wdata[31:0] = 32'hCAFE_F00D;
    @(negedge clk); #2;
    check("dw32_cs", c32_cs, 1);
    check("dw32_addr", c32_raddr, 14'h0002);
    check("dw32_wem", c32_wem, 4'h3);
    check("dw32_din", c32_din, 32'hCAFE_F00D);
    @(posedge clk); #1 c32_valid = '0;

    // Directed write / read through both lanes
    drive_cmd(1, 16'h0104, 1'b0, 32'hDEADBEEF, 4'hF); wait_accept(1);
    check("wr_ram_addr", ram_addr, 13'h020);
    check("wr_ram_wem", ram_wem, 8'hF0);
    check("wr_ram_din", ram_din, 64'hDEADBEEF_DEADBEEF);
    clear_cmd(1);
    @(negedge clk); #2;
    check("wr_rsp_valid", icb_rsp_valid, 3'b010);
    check("wr_rsp_rdata", icb_rsp_rdata[63:32], 32'h0);
    drive_cmd(1, 16'h0100, 1'b0, 32'h12345678, 4'hF); wait_accept(1); clear_cmd(1);
    drive_cmd(0, 16'h0104, 1'b1, 32'h0, 4'h0); wait_accept(0); clear_cmd(0);
    @(negedge clk); #2;
    check("rd_hi_lane", icb_rsp_rdata[31:0], 32'hDEADBEEF);
    drive_cmd(0, 16'h0100, 1'b1, 32'h0, 4'h0); wait_accept(0); clear_cmd(0);
    @(negedge clk); #2;
    check("rd_lo_lane", icb_rsp_rdata[31:0], 32'h12345678);

    // Stalled response: hold register, slot busy, RAM idle
    drive_cmd(2, 16'h0104, 1'b1, 32'h0, 4'h0); icb_rsp_ready[2] = 1'b0;
    wait_accept(2);
    @(posedge clk); #1;
    icb_cmd_valid[2] = 1'b0;
    set_cmd(0, 16'h0100, 1'b1, 32'h0, 4'h0);
    repeat (3) begin
      @(negedge clk); #2;
      check("hold_rsp_valid", icb_rsp_valid, 3'b100);
      check("hold_rdata", icb_rsp_rdata[95:64], 32'hDEADBEEF);
      check("hold_cmd_ready", icb_cmd_ready, 0);
      check("hold_ram_cs", ram_cs, 0);
      @(posedge clk); #1;
    end
    icb_rsp_ready[2] = 1'b1;
    wait_accept(0);
    check("hold_release", icb_rsp_rdata[95:64], 32'hDEADBEEF);
    clear_cmd(0);

    // Reset with a response outstanding
    drive_cmd(0, 16'h0100, 1'b1, 32'h0, 4'h0); icb_rsp_ready[0] = 1'b0;
    wait_accept(0); clear_cmd(0);
    @(negedge clk); #2;
    check("pre_rst_rsp_valid", icb_rsp_valid, 3'b001);
    chk_en = 0; rst_n = 1'b0;
    #1;
    check("rst_async_rsp_valid", icb_rsp_valid, 0);
    check("rst_async_active", tcm_active, 0);
    sb.delete(); icb_rsp_ready = '1; m_last = N - 1;
    @(posedge clk); #3;
    rst_n = 1'b1; chk_en = 1;

    // All ports requesting continuously
    @(posedge clk); #1;
    for (int p = 0; p < N; p++) set_cmd(p, 16'(p * 8 + 64), 1'b1, 32'h0, 4'h0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); #2;
      eg = '0; eg[arb_exp[i]] = 1'b1;
      check("arb_grant", icb_cmd_ready, eg);
    end
    @(posedge clk); #1 icb_cmd_valid = '0;

    // Random traffic against the reference model
    acc = '0;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      for (int p = 0; p < N; p++) begin
        if (!icb_cmd_valid[p] || acc[p]) begin
          if ($urandom_range(0, 2) != 0)
            set_cmd(p, 16'($urandom_range(0, 511)), 1'($urandom_range(0, 1)),
                    $urandom, 4'($urandom_range(0, 15)));
          else
            icb_cmd_valid[p] = 1'b0;
        end
      end
      icb_rsp_ready = N'($urandom);
      @(negedge clk); #2;
      acc = icb_cmd_valid & icb_cmd_ready;
    end
    @(posedge clk); #1;
    icb_cmd_valid = '0; icb_rsp_ready = '1;
    repeat (5) @(negedge clk);
    #2;
    check("drain", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
